ssd_scan_controller: RTL and testbench

Sequencing controller for the four-digit seven-segment display path. Accepts a binary value through a load/busy handshake, converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine, and applies leading-zero blanking. Drives the display multiplexer's 16-bit digit bus and 2-bit digit-select from a free-running refresh prescaler. Sits between game/score logic and the digit-multiplex/decode stage.

---
 rtl/ssd_scan_controller.sv | 130 +++++++++++++
 tb/tb_ssd_scan_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_controller.sv
// Seven-segment scan controller: load/busy handshake, iterative double-dabble
// binary-to-BCD conversion, leading-zero blanking and a free-running refresh
// prescaler driving the digit select.
module ssd_scan_controller #(
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        display_off,
  output logic        busy,
  output logic        ovf,
  output logic [15:0] nums,
  output logic [1:0]  ssd_ctl_en
);

  localparam int unsigned VAL_W    = 14;
  localparam int unsigned BCD_W    = 16;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DIGITS   = 4;
  localparam logic [VAL_W-1:0] VAL_MAX   = VAL_W'(9999);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(VAL_W - 1);
  localparam logic [BCD_W-1:0] DISP_RST  = 16'hFFF0;
  localparam logic [3:0]       BLANK     = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [VAL_W-1:0]        bin_q, bin_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, busy_d;
  logic [BCD_W-1:0]        disp_q, disp_d;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;

  logic [BCD_W-1:0]        adj;
  logic [BCD_W-1:0]        blanked;
  logic                    lead;

  // Add-3 correction on each BCD nibble ahead of the shift
  always_comb begin
    adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
  end

  // Leading-zero blanking of the finished BCD word; ones digit always shown
  always_comb begin
    blanked = bcd_q;
    lead    = blank_lz;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (lead && (bcd_q[4*k +: 4] == 4'd0)) blanked[4*k +: 4] = BLANK;
      else                                   lead = 1'b0;
    end
  end

  // Next-state and datapath updates for the conversion sequencer
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    disp_d    = disp_q;
    refresh_d = refresh_q + REFRESH_BITS'(1);

    case (state_q)
      IDLE: begin
        if (load) begin
          ovf_d   = (value > VAL_MAX);
          bin_d   = (value > VAL_MAX) ? VAL_MAX : value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = BCD_W'({adj, bin_q[VAL_W-1]});
        bin_d = {bin_q[VAL_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = LATCH;
      end
      LATCH: begin
        disp_d  = blanked;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      disp_q    <= DISP_RST;
      refresh_q <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      disp_q    <= disp_d;
      refresh_q <= refresh_d;
    end
  end

  assign busy       = busy_q;
  assign ovf        = ovf_q;
  assign nums       = display_off ? 16'hFFFF : disp_q;
  assign ssd_ctl_en = refresh_q[REFRESH_BITS-1 -: 2];

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Bench for ssd_scan_controller: directed and randomized loads against a
// decimal-arithmetic reference model, plus refresh, display_off and reset checks.
module tb_ssd_scan_controller;

  localparam int unsigned RB = 4;

  logic        clk;
  logic        rst;
  logic [13:0] value;
  logic        load;
  logic        blank_lz;
  logic        display_off;
  logic        busy;
  logic        ovf;
  logic [15:0] nums;
  logic [1:0]  ssd_ctl_en;

  int unsigned checks;
  int unsigned errors;
  int unsigned tb_cyc;
  logic [15:0] disp_model;
  logic        ovf_model;

  ssd_scan_controller #(.REFRESH_BITS(RB)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .load        (load),
    .blank_lz    (blank_lz),
    .display_off (display_off),
    .busy        (busy),
    .ovf         (ovf),
    .nums        (nums),
    .ssd_ctl_en  (ssd_ctl_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock edges seen since reset was last released
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Expected display word from decimal digits of the clamped value
  function automatic logic [15:0] model_nums(input int v, input bit blz);
    int c;
    int d [4];
    bit lead;
    logic [15:0] r;
    c = (v > 9999) ? 9999 : v;
    d[0] = c % 10;
    d[1] = (c / 10) % 10;
    d[2] = (c / 100) % 10;
    d[3] = c / 1000;
    r = '0;
    lead = blz;
    for (int k = 3; k >= 0; k--) begin
      if (lead && k > 0 && d[k] == 0) r[4*k +: 4] = 4'hF;
      else begin
        r[4*k +: 4] = 4'(d[k]);
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ssd();
    check("ssd_ctl_en", 32'(ssd_ctl_en), 32'((tb_cyc / 4) % 4));
  endtask

  // One accepted load; stray loads during busy either at stray_idx or randomly
  task automatic do_load(input logic [13:0] v, input bit blz, input int stray_idx, input bit rnd_stray);
    logic [15:0] exp_n;
    exp_n = model_nums(int'(v), blz);
    value = v;
    blank_lz = blz;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("busy_during_conv", 32'(busy), 32'd1);
      check("nums_hold", 32'(nums), 32'(disp_model));
      check_ssd();
      if (i + 1 == stray_idx) begin
        value = 14'd1;
        load = 1'b1;
      end else if (rnd_stray && $urandom_range(0, 2) == 0) begin
        value = 14'($urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    disp_model = exp_n;
    ovf_model = (v > 14'd9999);
    check("busy_done", 32'(busy), 32'd0);
    check("nums_result", 32'(nums), 32'(disp_model));
    check("ovf", 32'(ovf), 32'(ovf_model));
  endtask

  initial begin
    logic [13:0] rv;
    bit rb;
    checks = 0;
    errors = 0;
    disp_model = 16'hFFF0;
    ovf_model = 1'b0;
    rst = 1'b1;
    load = 1'b0;
    value = '0;
    blank_lz = 1'b0;
    display_off = 1'b0;

    // Reset values visible before any clock edge
    #3;
    check("rst_nums", 32'(nums), 32'h0000_FFF0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ssd", 32'(ssd_ctl_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values from the test plan
    do_load(14'd1234, 1'b1, -1, 1'b0);
    do_load(14'd7, 1'b1, -1, 1'b0);
    do_load(14'd7, 1'b0, -1, 1'b0);
    do_load(14'd0, 1'b1, -1, 1'b0);
    do_load(14'd1005, 1'b1, -1, 1'b0);
    do_load(14'd12000, 1'b1, -1, 1'b0);
    do_load(14'd42, 1'b1, -1, 1'b0);
    // Stray load at E5 ignored, back-to-back load at E16 accepted
    do_load(14'd9999, 1'b1, 5, 1'b0);
    do_load(14'd1, 1'b1, -1, 1'b0);

    // Refresh keeps stepping while idle
    repeat (20) begin
      @(negedge clk);
      check_ssd();
    end

    // display_off forces blank immediately and releases immediately
    display_off = 1'b1;
    #1;
    check("doff_on", 32'(nums), 32'h0000_FFFF);
    check("doff_ovf", 32'(ovf), 32'(ovf_model));
    @(negedge clk);
    check("doff_held", 32'(nums), 32'h0000_FFFF);
    display_off = 1'b0;
    #1;
    check("doff_off", 32'(nums), 32'(disp_model));

    // Reset in the middle of a conversion
    @(negedge clk);
    value = 14'd5678;
    blank_lz = 1'b1;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    disp_model = 16'hFFF0;
    ovf_model = 1'b0;
    check("midrst_nums", 32'(nums), 32'h0000_FFF0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    check("midrst_ssd", 32'(ssd_ctl_en), 32'd0);
    @(negedge clk);
    check("midrst_hold", 32'(nums), 32'h0000_FFF0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    do_load(14'd5678, 1'b1, -1, 1'b0);

    // Randomized loads with random ignored requests while busy
    for (int n = 0; n < 24; n++) begin
      rv = 14'($urandom);
      if ($urandom_range(0, 1) == 1) rv = 14'($urandom_range(0, 120));
      rb = 1'($urandom);
      do_load(rv, rb, -1, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check_ssd();
        check("idle_nums", 32'(nums), 32'(disp_model));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
